// File: rtl/memory_map_pkg.sv
// Shared address map, I/O register addresses and timer bit positions for the
// nibble-wide memory map and its clock timer.
package memory_map_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 4;
  localparam int RAM_DEPTH  = 640;
  localparam int VRAM_DEPTH = 256;

  localparam logic [ADDR_W-1:0] RAM_LAST   = 12'h27F;
  localparam logic [ADDR_W-1:0] VRAM_BASE  = 12'hE00;
  localparam logic [ADDR_W-1:0] VRAM_LAST  = 12'hEFF;
  localparam logic [ADDR_W-1:0] ADDR_IT    = 12'hF00;
  localparam logic [ADDR_W-1:0] ADDR_EIT   = 12'hF10;
  localparam logic [ADDR_W-1:0] ADDR_TM_LO = 12'hF20;
  localparam logic [ADDR_W-1:0] ADDR_TM_HI = 12'hF21;
  localparam logic [ADDR_W-1:0] ADDR_K0    = 12'hF40;
  localparam logic [ADDR_W-1:0] ADDR_TMRST = 12'hF76;

  // IT flag positions and the TM bit whose falling edge sets each of them
  localparam int IT_32HZ     = 0;
  localparam int IT_8HZ      = 1;
  localparam int IT_2HZ      = 2;
  localparam int IT_1HZ      = 3;
  localparam int TM_SRC_32HZ = 2;
  localparam int TM_SRC_8HZ  = 4;
  localparam int TM_SRC_2HZ  = 6;
  localparam int TM_SRC_1HZ  = 7;
  localparam int TMRST_BIT   = 1;

  typedef enum logic [3:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_VRAM,
    RGN_IT,
    RGN_EIT,
    RGN_TM_LO,
    RGN_TM_HI,
    RGN_K0,
    RGN_TMRST
  } region_e;

  function automatic region_e decode_addr(input logic [ADDR_W-1:0] addr);
    region_e rgn;
    rgn = RGN_NONE;
    if (addr <= RAM_LAST)                           rgn = RGN_RAM;
    else if (addr >= VRAM_BASE && addr <= VRAM_LAST) rgn = RGN_VRAM;
    else if (addr == ADDR_IT)                       rgn = RGN_IT;
    else if (addr == ADDR_EIT)                      rgn = RGN_EIT;
    else if (addr == ADDR_TM_LO)                    rgn = RGN_TM_LO;
    else if (addr == ADDR_TM_HI)                    rgn = RGN_TM_HI;
    else if (addr == ADDR_K0)                       rgn = RGN_K0;
    else if (addr == ADDR_TMRST)                    rgn = RGN_TMRST;
    return rgn;
  endfunction

endpackage

// File: rtl/memory_map_if.sv
// Register-access link between the memory map decoder (master) and the clock timer (slave).
interface memory_map_if;
  import memory_map_pkg::*;

  // No handshake: every strobe is a single-cycle qualifier valid only in the
  // cycle it is high and always accepted; status signals are registered state.
  logic              tick;
  logic              it_rd;
  logic              eit_wr;
  logic              tmrst;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        tm;
  logic [DATA_W-1:0] it;
  logic [DATA_W-1:0] eit;
  logic              irq;

  modport master (output tick, it_rd, eit_wr, tmrst, wdata,
                  input  tm, it, eit, irq);
  modport slave  (input  tick, it_rd, eit_wr, tmrst, wdata,
                  output tm, it, eit, irq);
endinterface

// File: rtl/memory_map_clock_timer.sv
// 256 Hz timebase counter TM with falling-edge interrupt flags IT, enable mask EIT and irq.
module clock_timer
  import memory_map_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  memory_map_if.slave  bus
);

  logic [7:0]        tm_q, tm_d;
  logic [DATA_W-1:0] it_q, it_d;
  logic [DATA_W-1:0] eit_q, eit_d;
  logic [DATA_W-1:0] it_set;
  logic              irq_q, irq_d;
  logic              tick_eff;

  always_comb begin
    // A TM clear swallows the tick and must not look like counter edges
    tick_eff = bus.tick && !bus.tmrst;
    tm_d     = tm_q;
    if (bus.tmrst)    tm_d = '0;
    else if (bus.tick) tm_d = tm_q + 8'd1;

    it_set          = '0;
    it_set[IT_32HZ] = tick_eff && tm_q[TM_SRC_32HZ] && !tm_d[TM_SRC_32HZ];
    it_set[IT_8HZ]  = tick_eff && tm_q[TM_SRC_8HZ]  && !tm_d[TM_SRC_8HZ];
    it_set[IT_2HZ]  = tick_eff && tm_q[TM_SRC_2HZ]  && !tm_d[TM_SRC_2HZ];
    it_set[IT_1HZ]  = tick_eff && tm_q[TM_SRC_1HZ]  && !tm_d[TM_SRC_1HZ];

    it_d  = (bus.it_rd ? '0 : it_q) | it_set;
    eit_d = bus.eit_wr ? bus.wdata : eit_q;
    irq_d = |(it_d & eit_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tm_q  <= '0;
      it_q  <= '0;
      eit_q <= '0;
      irq_q <= 1'b0;
    end else begin
      tm_q  <= tm_d;
      it_q  <= it_d;
      eit_q <= eit_d;
      irq_q <= irq_d;
    end
  end

  assign bus.tm  = tm_q;
  assign bus.it  = it_q;
  assign bus.eit = eit_q;
  assign bus.irq = irq_q;

endmodule

// File: rtl/memory_map.sv
// CPU nibble address decoder with RAM, dual-ported VRAM, timer/keypad I/O and a registered read mux.
module memory_map
  import memory_map_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              memory_write_en,
  input  logic [ADDR_W-1:0] memory_addr,
  input  logic [DATA_W-1:0] memory_write_data,
  output logic [DATA_W-1:0] memory_read_data,
  input  logic              tick_256hz,
  input  logic [DATA_W-1:0] input_k0,
  input  logic [7:0]        video_addr,
  output logic [DATA_W-1:0] video_data,
  output logic              irq
);

  region_e           rgn;
  logic              cpu_wr, cpu_rd;
  logic [9:0]        ram_idx;
  logic [7:0]        vram_idx;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] video_q;

  logic [DATA_W-1:0] ram_q  [RAM_DEPTH];
  logic [DATA_W-1:0] vram_q [VRAM_DEPTH];

  memory_map_if tmr_if ();

  assign rgn      = decode_addr(memory_addr);
  assign cpu_wr   = memory_write_en;
  assign cpu_rd   = !memory_write_en;
  assign ram_idx  = memory_addr[9:0];
  // VRAM base is 256-aligned, so the low byte is the VRAM offset
  assign vram_idx = memory_addr[7:0];

  assign tmr_if.tick   = tick_256hz;
  assign tmr_if.it_rd  = cpu_rd && (rgn == RGN_IT);
  assign tmr_if.eit_wr = cpu_wr && (rgn == RGN_EIT);
  assign tmr_if.tmrst  = cpu_wr && (rgn == RGN_TMRST) && memory_write_data[TMRST_BIT];
  assign tmr_if.wdata  = memory_write_data;

  clock_timer u_clock_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (tmr_if.slave)
  );

  // Array contents are never reset; reset only blocks writes
  always_ff @(posedge clk) begin
    if (reset_n && cpu_wr && rgn == RGN_RAM)  ram_q[ram_idx]   <= memory_write_data;
    if (reset_n && cpu_wr && rgn == RGN_VRAM) vram_q[vram_idx] <= memory_write_data;
  end

  always_comb begin
    rd_mux = '0;
    unique case (rgn)
      RGN_RAM:   rd_mux = ram_q[ram_idx];
      RGN_VRAM:  rd_mux = vram_q[vram_idx];
      RGN_IT:    rd_mux = tmr_if.it;
      RGN_EIT:   rd_mux = tmr_if.eit;
      RGN_TM_LO: rd_mux = tmr_if.tm[3:0];
      RGN_TM_HI: rd_mux = tmr_if.tm[7:4];
      RGN_K0:    rd_mux = input_k0;
      default:   rd_mux = '0;
    endcase
    rdata_d = cpu_rd ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
      video_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      video_q <= vram_q[video_addr];
    end
  end

  assign memory_read_data = rdata_q;
  assign video_data       = video_q;
  assign irq              = tmr_if.irq;

endmodule

// File: tb/tb_memory_map.sv
// Randomized and directed checks of memory_map against a cycle-level behavioural model.
module tb_memory_map;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memory_write_en;
  logic [11:0] memory_addr;
  logic [3:0]  memory_write_data;
  logic [3:0]  memory_read_data;
  logic        tick_256hz;
  logic [3:0]  input_k0;
  logic [7:0]  video_addr;
  logic [3:0]  video_data;
  logic        irq;

  // clock / reset
  always #5 clk = ~clk;

  memory_map dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .memory_write_en   (memory_write_en),
    .memory_addr       (memory_addr),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data),
    .tick_256hz        (tick_256hz),
    .input_k0          (input_k0),
    .video_addr        (video_addr),
    .video_data        (video_data),
    .irq               (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_video = 1'b0;

  // behavioural model state
  int         m_tm;
  logic [3:0] m_it, m_eit, m_rd;
  logic       m_irq;
  logic [3:0] m_ram  [640];
  logic [3:0] m_vram [256];
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_read(input int a, input logic [3:0] k0);
    if (a <= 'h27F) return m_ram[a];
    if (a >= 'hE00 && a <= 'hEFF) return m_vram[a - 'hE00];
    case (a)
      'hF00:   return m_it;
      'hF10:   return m_eit;
      'hF20:   return 4'(m_tm % 16);
      'hF21:   return 4'(m_tm / 16);
      'hF40:   return k0;
      default: return 4'h0;
    endcase
  endfunction

  // driver: one clock cycle with the given inputs, model update, output checks
  task automatic step(input logic rst_n, input logic we, input logic [11:0] a,
                      input logic [3:0] wd, input logic tk, input logic [3:0] k0,
                      input logic [7:0] va);
    logic [3:0] set;
    logic [3:0] exp_vd;
    int ai;
    reset_n = rst_n; memory_write_en = we; memory_addr = a;
    memory_write_data = wd; tick_256hz = tk; input_k0 = k0; video_addr = va;
    ai = int'(a);
    set = 4'h0;
    exp_vd = 4'h0;
    if (!rst_n) begin
      m_rd = 4'h0; m_tm = 0; m_it = 4'h0; m_eit = 4'h0;
    end else begin
      exp_vd = m_vram[va];
      if (!we) m_rd = model_read(ai, k0);
      if (we && ai == 'hF76 && wd[1]) m_tm = 0;
      else if (tk) begin
        m_tm = (m_tm + 1) % 256;
        if (m_tm % 8 == 0)   set[0] = 1'b1;
        if (m_tm % 32 == 0)  set[1] = 1'b1;
        if (m_tm % 128 == 0) set[2] = 1'b1;
        if (m_tm == 0)       set[3] = 1'b1;
      end
      if (!we && ai == 'hF00) m_it = 4'h0;
      m_it = m_it | set;
      if (we && ai == 'hF10) m_eit = wd;
      if (we && ai <= 'h27F) m_ram[ai] = wd;
      if (we && ai >= 'hE00 && ai <= 'hEFF) m_vram[ai - 'hE00] = wd;
    end
    m_irq = rst_n ? |(m_it & m_eit) : 1'b0;
    exp_q.push_back(m_rd);
    @(posedge clk);
    #1;
    check("rdata", memory_read_data, exp_q.pop_front());
    check("irq", {3'b0, irq}, {3'b0, m_irq});
    if (chk_video) check("video", video_data, exp_vd);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, 1'b0, a, 4'h0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 12'h010, 4'hF, 1'b1, 4'h0, 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 12'h000, 4'h0, 1'b1, 4'h0, 8'h00);
  endtask

  initial begin
    logic [11:0] a;
    reset_n = 1'b0; memory_write_en = 1'b0; memory_addr = '0; memory_write_data = '0;
    tick_256hz = 1'b0; input_k0 = '0; video_addr = '0;
    #1;
    do_reset();
    do_reset();
    check("reset_rdata", memory_read_data, 4'h0);
    check("reset_irq", {3'b0, irq}, 4'h0);
    check("reset_video", video_data, 4'h0);

    for (int i = 0; i < 640; i++) wr(12'(i), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 256; i++) wr(12'('hE00 + i), 4'($urandom_range(0, 15)));
    chk_video = 1'b1;

    // write then read back; the write cycle leaves read data alone
    rd(12'hF10);
    wr(12'h123, 4'h5);
    check("wr_hold", memory_read_data, 4'h0);
    rd(12'h123);
    check("rd_123", memory_read_data, 4'h5);

    // reset during a write must not reach RAM, and TM/EIT are cleared
    do_reset();
    rd(12'h010);

    // eight ticks set the 32 Hz flag, irq follows, IT read clears both
    do_reset();
    wr(12'hF10, 4'h1);
    ticks(8);
    check("irq_32hz", {3'b0, irq}, 4'h1);
    rd(12'hF20);
    check("tm_8", memory_read_data, 4'h8);
    rd(12'hF00);
    check("it_rd_1", memory_read_data, 4'h1);
    check("irq_clr", {3'b0, irq}, 4'h0);
    rd(12'hF00);
    check("it_after_clr", memory_read_data, 4'h0);

    // full wrap sets every flag
    do_reset();
    wr(12'hF10, 4'hF);
    ticks(256);
    check("irq_wrap", {3'b0, irq}, 4'h1);
    rd(12'hF21);
    check("tm_hi_wrap", memory_read_data, 4'h0);
    rd(12'hF20);
    check("tm_lo_wrap", memory_read_data, 4'h0);
    rd(12'hF00);
    check("it_wrap", memory_read_data, 4'hF);

    // IT read coincident with the setting tick: set wins, read excludes it
    do_reset();
    ticks(7);
    step(1'b1, 1'b0, 12'hF00, 4'h0, 1'b1, 4'h0, 8'h00);
    check("it_race_rd", memory_read_data, 4'h0);
    rd(12'hF00);
    check("it_race_after", memory_read_data, 4'h1);

    // TM clear at 0xA7 with a coincident tick; IT untouched
    do_reset();
    ticks(167);
    step(1'b1, 1'b1, 12'hF76, 4'h2, 1'b1, 4'h0, 8'h00);
    rd(12'hF21);
    check("tmrst_hi", memory_read_data, 4'h0);
    rd(12'hF20);
    check("tmrst_lo", memory_read_data, 4'h0);
    rd(12'hF00);
    check("tmrst_it", memory_read_data, 4'h7);
    ticks(5);
    wr(12'hF76, 4'hD);
    rd(12'hF20);
    check("tmrst_bit1_0", memory_read_data, 4'h5);

    // unmapped reads, read-only writes, K0 and the video port
    rd(12'h300);
    check("unmapped_300", memory_read_data, 4'h0);
    wr(12'hFFF, 4'hA);
    rd(12'hFFF);
    check("unmapped_fff", memory_read_data, 4'h0);
    wr(12'hF20, 4'hC);
    rd(12'hF20);
    check("tm_ro", memory_read_data, 4'h5);
    step(1'b1, 1'b0, 12'hF40, 4'h0, 1'b0, 4'hA, 8'h00);
    check("k0", memory_read_data, 4'hA);
    wr(12'hE82, 4'h9);
    step(1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 8'h82);
    check("video_82", video_data, 4'h9);
    step(1'b1, 1'b1, 12'hE82, 4'h3, 1'b0, 4'h0, 8'h82);
    check("video_collide", video_data, 4'h9);
    step(1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 8'h82);
    check("video_new", video_data, 4'h3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 12'($urandom_range(0, 'h27F));
        4:          a = 12'('hE00 + $urandom_range(0, 255));
        5:          a = 12'hF00;
        6:          a = 12'hF10;
        7:          a = 12'('hF20 + $urandom_range(0, 1));
        8:          a = ($urandom_range(0, 1) == 0) ? 12'hF40 : 12'hF76;
        default:    a = 12'($urandom_range(0, 4095));
      endcase
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) == 0), a,
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
